load_store_unit: RTL and testbench

//  Multi-cycle data-memory access stage between the core's address/store-data path and the

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/load_align_ext.sv | 36 +++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states, byte strobes
// and the legality / store-lane helpers used by the request latch.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Size/sign code valid for the op and the address naturally aligned
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            F3_B:    s = STRB_B << off;
            F3_H:    s = STRB_H << off;
            default: s = STRB_W;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{sd[7:0]}};
            F3_H:    d = {2{sd[15:0]}};
            default: d = sd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result_c = rdata;
        case (funct3)
            F3_B:    result_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_c = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result_c = {24'd0, byte_sel};
            F3_HU:   result_c = {16'd0, half_sel};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: validates and latches one access, runs it on the bus
// under a watchdog, and stalls the core until the load result or store ack is back.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  access_error,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_we,
    output logic [3:0]            bus_wstrb,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_rsp_valid,
    input  logic [31:0]           bus_rdata
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WORD_W = ADDR_WIDTH - 2;

    lsu_state_e        state;
    logic [WORD_W-1:0] word_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              is_store_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       aligned_c;

    logic legal_op;
    logic idle_active;
    logic in_bus;
    logic timeout;
    logic in_req;

    assign legal_op    = (mem_read ^ mem_write) && access_legal(mem_write, funct3, addr[1:0]);
    assign idle_active = (state == S_IDLE) && !reset;
    assign in_bus      = (state == S_REQ) || (state == S_WAIT);
    assign in_req      = (state == S_REQ);
    assign timeout     = in_bus && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Accept/reject decision and watchdog abort act in the same cycle they are seen
    assign stall         = (idle_active && legal_op) || (in_bus && !timeout);
    assign access_error  = (idle_active && (mem_read || mem_write) && !legal_op) || timeout;
    assign bus_req_valid = in_req && !timeout;
    assign bus_addr      = in_req ? {word_q, 2'b00} : '0;
    assign bus_we        = in_req && is_store_q;
    assign bus_wstrb     = in_req ? wstrb_q : STRB_NONE;
    assign bus_wdata     = in_req ? wdata_q : 32'd0;
    assign load_valid    = (state == S_DONE) && !is_store_q;

    load_align_ext u_align (
        .rdata    (bus_rdata),
        .offset   (off_q),
        .funct3   (f3_q),
        .result_c (aligned_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            word_q     <= '0;
            off_q      <= 2'd0;
            f3_q       <= 3'd0;
            is_store_q <= 1'b0;
            wstrb_q    <= STRB_NONE;
            wdata_q    <= 32'd0;
            cnt_q      <= '0;
            load_data  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (legal_op) begin
                        state      <= S_REQ;
                        word_q     <= addr[ADDR_WIDTH-1:2];
                        off_q      <= addr[1:0];
                        f3_q       <= funct3;
                        is_store_q <= mem_write;
                        wstrb_q    <= mem_write ? store_strobe(funct3, addr[1:0]) : STRB_NONE;
                        wdata_q    <= mem_write ? store_lanes(funct3, store_data) : 32'd0;
                        cnt_q      <= '0;
                    end
                end
                S_REQ: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (bus_req_ready) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (bus_rsp_valid) begin
                            if (!is_store_q) load_data <= aligned_c;
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets per-cycle expectations
// and one negedge process compares every DUT output against them.
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, access_error;
    logic [31:0] load_data;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en;
    logic        exp_stall, exp_err, exp_reqv, exp_lv, exp_we;
    logic [31:0] exp_addr, exp_wdata, model_ld;
    logic [3:0]  exp_strb;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_strb;
    logic        seen_we;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .access_error(access_error),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference rules: sizes in bytes, natural alignment, lane arithmetic
    function automatic logic m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int nbytes;
        if (rd == wr) return 1'b0;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        nbytes = 1 << int'(f3[1:0]);
        return (int'(a[1:0]) % nbytes) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        logic [3:0] s;
        nbytes = 1 << int'(f3[1:0]);
        s = 4'((32'd1 << nbytes) - 32'd1);
        return s << a[1:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'd0:    return 32'(sd[7:0]) * 32'h0101_0101;
            2'd1:    return 32'(sd[15:0]) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] f3);
        int nbits;
        logic [31:0] v, mask;
        nbits = 8 << int'(f3[1:0]);
        v = rd >> (8 * int'(a[1:0]));
        mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        v = v & mask;
        if (!f3[2] && nbits < 32 && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle comparison against the expectations the stimulus publishes
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("access_error", 32'(access_error), 32'(exp_err));
            check("bus_req_valid", 32'(bus_req_valid), 32'(exp_reqv));
            check("load_valid", 32'(load_valid), 32'(exp_lv));
            check("load_data", load_data, model_ld);
            if (exp_reqv) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", 32'(bus_we), 32'(exp_we));
                check("bus_wstrb", 32'(bus_wstrb), 32'(exp_strb));
                check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (bus_req_valid && bus_req_ready) begin
                seen_addr  = bus_addr;
                seen_we    = bus_we;
                seen_strb  = bus_wstrb;
                seen_wdata = bus_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic e, input logic r, input logic l);
        exp_stall = s; exp_err = e; exp_reqv = r; exp_lv = l;
    endtask

    task automatic drive_idle();
        mem_read = 1'b0; mem_write = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // rdy_wait: non-ready REQ cycles before ready (-1 never); rsp_wait: WAIT cycle of rsp (0 never)
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                             input int rdy_wait, input int rsp_wait);
        logic legal, got, in_req;
        int rq, wt;
        legal = m_legal(rd, wr, f3, a);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        set_exp(legal, (rd | wr) & ~legal, 1'b0, 1'b0);
        step();
        if (!legal) begin
            drive_idle();
            return;
        end
        exp_addr = {a[31:2], 2'b00};
        exp_we = wr;
        exp_strb = wr ? m_strb(f3, a) : 4'b0000;
        exp_wdata = wr ? m_wdata(f3, sd) : 32'd0;
        rq = 0; wt = 0; in_req = 1'b1; got = 1'b0;
        for (int k = 1; k <= TO && !got; k++) begin
            if (in_req) begin
                bus_req_ready = (rdy_wait >= 0) && (rq == rdy_wait);
                bus_rsp_valid = bus_req_ready;
                bus_rdata = ~rdat;
            end else begin
                bus_req_ready = 1'b0;
                bus_rsp_valid = (rsp_wait != 0) && (wt + 1 == rsp_wait);
                bus_rdata = bus_rsp_valid ? rdat : ~rdat;
            end
            if (k == TO) begin
                set_exp(1'b0, 1'b1, 1'b0, 1'b0);
                step();
                drive_idle();
                return;
            end
            set_exp(1'b1, 1'b0, in_req, 1'b0);
            step();
            if (in_req) begin
                if (bus_req_ready) in_req = 1'b0;
                rq++;
            end else begin
                wt++;
                if (bus_rsp_valid) got = 1'b1;
            end
        end
        if (rd) model_ld = m_load(rdat, a, f3);
        bus_rsp_valid = 1'b1;
        bus_rdata = ~rdat;
        set_exp(1'b0, 1'b0, 1'b0, rd);
        step();
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; chk_en = 1'b0; model_ld = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
        exp_addr = 32'd0; exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0;
        seen_addr = 32'd0; seen_we = 1'b0; seen_strb = 4'd0; seen_wdata = 32'd0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req_valid", 32'(bus_req_valid), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        do_access(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 2);
        check("lw_data", load_data, 32'hDEAD_BEEF);
        do_access(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 1, 1);
        check("lb_data", load_data, 32'hFFFF_FF80);
        do_access(1, 0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 0, 1);
        check("lbu_data", load_data, 32'h0000_0080);
        do_access(1, 0, 3'b001, 32'h102, 32'd0, 32'h8001_0000, 0, 3);
        check("lh_data", load_data, 32'hFFFF_8001);
        do_access(1, 0, 3'b101, 32'h102, 32'd0, 32'h8001_0000, 2, 1);
        do_access(1, 0, 3'b001, 32'h100, 32'd0, 32'h1234_7FFE, 0, 1);
        do_access(1, 0, 3'b000, 32'h101, 32'd0, 32'h0000_7F00, 0, 1);

        do_access(0, 1, 3'b000, 32'h201, 32'h1234_5678, 32'd0, 2, 1);
        check("sb_addr", seen_addr, 32'h200);
        check("sb_we", 32'(seen_we), 32'd1);
        check("sb_strb", 32'(seen_strb), 32'h2);
        check("sb_wdata", seen_wdata, 32'h7878_7878);
        check("sb_keeps_load_data", load_data, 32'h0000_007F);
        do_access(0, 1, 3'b001, 32'h202, 32'h1234_5678, 32'd0, 0, 2);
        check("sh_strb", 32'(seen_strb), 32'hC);
        check("sh_wdata", seen_wdata, 32'h5678_5678);
        do_access(0, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'd0, 0, 1);
        do_access(0, 1, 3'b000, 32'h20E, 32'hAAAA_AA5C, 32'd0, 1, 2);

        do_access(1, 0, 3'b010, 32'h102, 32'd0, 32'd0, 0, 1);
        do_access(0, 1, 3'b001, 32'h101, 32'h1, 32'd0, 0, 1);
        do_access(1, 0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 1);
        do_access(0, 1, 3'b100, 32'h100, 32'h1, 32'd0, 0, 1);
        do_access(1, 1, 3'b010, 32'h100, 32'h1, 32'd0, 0, 1);
        step();

        do_access(1, 0, 3'b010, 32'h400, 32'd0, 32'h1111_1111, -1, 0);
        do_access(0, 1, 3'b010, 32'h404, 32'h2, 32'd0, 0, 0);
        do_access(1, 0, 3'b010, 32'h408, 32'd0, 32'h0BAD_F00D, 0, 6);
        check("post_timeout_lw", load_data, 32'h0BAD_F00D);

        // Reset while waiting for the response
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        exp_addr = 32'h300; exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus_req_ready = 1'b1;
        set_exp(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        bus_req_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        #1 reset = 1'b1; chk_en = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_req_valid", 32'(bus_req_valid), 32'd0);
        check("midrst_error", 32'(access_error), 32'd0);
        check("midrst_load_data", load_data, 32'd0);
        model_ld = 32'd0;
        mem_read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_5555;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step();
        bus_rsp_valid = 1'b0;
        step();
        do_access(1, 0, 3'b010, 32'h300, 32'd0, 32'h1357_9BDF, 0, 1);
        check("post_reset_lw", load_data, 32'h1357_9BDF);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
